// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one branch comparator between two requesters.
//
// A three-state FSM (StIdle -> StExec -> StResp) accepts one request at a time,
// evaluates the latched compare in StExec and holds the registered result in
// StResp until the consumer takes it. When both requesters are valid, the
// 1-bit pointer prio_q picks the winner and then points at the loser, so
// continuous contention alternates 0,1,0,1...
//
// Ports:
//   clk                    single clock, rising edge
//   rst                    asynchronous active-low reset
//   reqN_valid/reqN_ready  request handshake per requester (ready is combinational)
//   reqN_cmpop             branch funct3 compare op
//   reqN_a, reqN_b         32-bit operands
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 index of the served requester
//   rsp_f                  compare result
//   grant_cnt0/1           saturating accept counters (only with CMP_ARB_STATS_EN)
//
// Build option: define CMP_ARB_STATS_EN to add grant_cnt0/grant_cnt1. CNT_WIDTH
// sets their width and has no effect otherwise.

module cmp_arbiter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic [2:0]           req0_cmpop,
    input  logic [2:0]           req1_cmpop,
    input  logic [31:0]          req0_a,
    input  logic [31:0]          req0_b,
    input  logic [31:0]          req1_a,
    input  logic [31:0]          req1_b,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic                 rsp_f,
    input  logic                 rsp_ready
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] grant_cnt0,
    output logic [CNT_WIDTH-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    state_t      state_q;
    logic        prio_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        id_q;

    logic        idle;
    logic        gnt1;
    logic        accept;
    logic        f;

    // Grant selection: a lone valid requester wins outright; under contention
    // prio_q decides.
    always_comb begin
        idle       = (state_q == StIdle);
        gnt1       = req1_valid && (!req0_valid || prio_q);
        req1_ready = idle && gnt1;
        req0_ready = idle && req0_valid && !gnt1;
        accept     = req0_ready || req1_ready;
    end

    // Undefined codes 010/011 fall through to unsigned >=, same as bgeu.
    always_comb begin
        f = 1'b0;
        case (op_q)
            3'b000:  f = (a_q == b_q);
            3'b001:  f = (a_q != b_q);
            3'b100:  f = ($signed(a_q) < $signed(b_q));
            3'b101:  f = ($signed(a_q) >= $signed(b_q));
            3'b110:  f = (a_q < b_q);
            default: f = (a_q >= b_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            prio_q    <= 1'b0;
            op_q      <= 3'b000;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_f     <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= gnt1 ? req1_cmpop : req0_cmpop;
                        a_q     <= gnt1 ? req1_a : req0_a;
                        b_q     <= gnt1 ? req1_b : req0_b;
                        id_q    <= gnt1;
                        // Point at the requester that lost this round.
                        prio_q  <= !gnt1;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_f     <= f;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

`ifdef CMP_ARB_STATS_EN
    // Saturating per-requester accept counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && req0_valid && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (req1_ready && req1_valid && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter. Expected responses are pushed to a
// queue when a request is driven and popped by a monitor on each response
// handshake. Inputs change 1ns after the rising edge; outputs are sampled on
// the falling edge or 1ns after the rising edge.

module tb_cmp_arbiter;

`ifdef CMP_ARB_STATS_EN
    localparam int unsigned CW = 2;
`else
    localparam int unsigned CW = 16;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_cmpop, req1_cmpop;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_id, rsp_f, rsp_ready;
`ifdef CMP_ARB_STATS_EN
    logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];   // {id, f}
    logic       m_prio;     // bench model of the priority pointer

    cmp_arbiter #(.CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_cmpop (req0_cmpop),
        .req1_cmpop (req1_cmpop),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_f      (rsp_f),
        .rsp_ready  (rsp_ready)
`ifdef CMP_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_f(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        logic r;
        case (op)
            3'd0:    r = (a == b);
            3'd1:    r = (a != b);
            3'd4:    r = ($signed(a) < $signed(b));
            3'd5:    r = !($signed(a) < $signed(b));
            3'd6:    r = (a < b);
            default: r = !(a < b);
        endcase
        return r;
    endfunction

    // Scoreboard consumer: one pop per response handshake.
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            logic [1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d f=%0d, required no response",
                         rsp_id, rsp_f);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_id, rsp_f} !== e) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d f=%0d, required id=%0d f=%0d",
                             rsp_id, rsp_f, e[1], e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // One request from a single requester, full handshake with latency checks.
    task automatic do_single(input logic id, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
        rsp_ready = 1'b1;
        req0_valid = !id;
        req1_valid = id;
        if (id) begin
            req1_cmpop = op; req1_a = a; req1_b = b;
        end else begin
            req0_cmpop = op; req0_a = a; req0_b = b;
        end
        #1;
        checks++;
        if (req0_ready !== !id || req1_ready !== id) begin
            errors++;
            $display("FAIL single_ready: got r0=%0d r1=%0d, required r0=%0d r1=%0d",
                     req0_ready, req1_ready, !id, id);
        end
        exp_q.push_back({id, ref_f(op, a, b)});
        m_prio = !id;
        tick();   // accept edge
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        // Scramble inputs; the in-flight result must not change.
        req0_a = ~a; req0_b = a; req1_a = ~a; req1_b = a;
        req0_cmpop = ~op; req1_cmpop = ~op;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL exec_rsp_valid: got %0d, required 0", rsp_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_rsp_valid: got %0d, required 1", rsp_valid);
        end
        tick();   // handshake edge, back to idle
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_cmpop = '0; req1_cmpop = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        m_prio = 1'b0;
        #23;
        checks++;
        if ({rsp_valid, rsp_id, rsp_f} !== 3'b000) begin
            errors++;
            $display("FAIL reset_rsp: got v/id/f=%b, required 000", {rsp_valid, rsp_id, rsp_f});
        end
`ifdef CMP_ARB_STATS_EN
        checks++;
        if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d, required 0/0", grant_cnt0, grant_cnt1);
        end
`endif
        tick();
        rst = 1'b1;
    endtask

    // Lone requesters, including one granted against the pointer.
    task automatic test_single();
        do_single(1'b0, 3'b100, 32'hFFFF_FFFF, 32'h1);   // signed: -1 < 1
        do_single(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1);   // unsigned: not <
        do_single(1'b1, 3'b000, 32'h5, 32'h5);           // prio=0, still req1
    endtask

    task automatic test_ops();
        logic [31:0] pa[4];
        logic [31:0] pb[4];
        pa[0] = 32'h5;         pb[0] = 32'h5;
        pa[1] = 32'hFFFF_FFFF; pb[1] = 32'h1;
        pa[2] = 32'h1;         pb[2] = 32'hFFFF_FFFF;
        pa[3] = 32'h8000_0000; pb[3] = 32'h7FFF_FFFF;
        for (int op = 0; op < 8; op++) begin
            for (int p = 0; p < 4; p++) begin
                do_single(1'(p), 3'(op), pa[p], pb[p]);
            end
        end
    endtask

    task automatic test_alternate();
        logic g;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_cmpop = 3'b000; req1_cmpop = 3'b000;
        req0_a = 32'd5; req0_b = 32'd5; req1_a = 32'd5; req1_b = 32'd5;
        m_prio = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (!(req0_ready || req1_ready) && n < 8) begin
                tick();
                n++;
            end
            checks++;
            if (n == 8) begin
                errors++;
                $display("FAIL alt_grant_timeout: got no ready, required a grant");
            end else begin
                g = m_prio;
                if (req0_ready !== !g || req1_ready !== g) begin
                    errors++;
                    $display("FAIL alt_grant: got r0=%0d r1=%0d, required r0=%0d r1=%0d",
                             req0_ready, req1_ready, !g, g);
                end
                exp_q.push_back({g, 1'b1});
                m_prio = !g;
                tick();
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        tick();
    endtask

    task automatic test_backpressure();
        // bge signed: -3 >= 2 is false
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_cmpop = 3'b101; req0_a = 32'hFFFF_FFFD; req0_b = 32'd2;
        #1;
        exp_q.push_back({1'b0, 1'b0});
        m_prio = 1'b1;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;   // keep both waiting
        tick();   // now in RESP
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_f, req0_ready, req1_ready} !== 5'b10000) begin
                errors++;
                $display("FAIL hold: got v/id/f/r0/r1=%b, required 10000",
                         {rsp_valid, rsp_id, rsp_f, req0_ready, req1_ready});
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: got v/r0/r1=%b, required 001",
                     {rsp_valid, req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        tick();
    endtask

    task automatic test_reset_exec();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_cmpop = 3'b000; req0_a = 32'd7; req0_b = 32'd7;
        #1;
        tick();   // accepted, now EXEC, DUT prio=1
        req0_valid = 1'b0;
        #2;
        rst = 1'b0;
        #2;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_exec_rsp: got %0d, required 0", rsp_valid);
        end
        rst = 1'b1;
        m_prio = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_rsp: got %0d, required 0", rsp_valid);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_cmpop = 3'b001; req0_a = 32'd1; req0_b = 32'd2;
        req1_cmpop = 3'b000; req1_a = 32'd1; req1_b = 32'd2;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_prio_grant: got r0=%0d r1=%0d, required r0=1 r1=0",
                     req0_ready, req1_ready);
        end
        exp_q.push_back({1'b0, 1'b1});
        m_prio = 1'b1;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        tick();
    endtask

`ifdef CMP_ARB_STATS_EN
    task automatic test_stats();
        test_reset();
        for (int i = 0; i < 5; i++) do_single(1'b0, 3'b000, 32'd1, 32'd1);
        checks++;
        if (grant_cnt0 !== 2'd3 || grant_cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL stats_sat: got %0d/%0d, required 3/0", grant_cnt0, grant_cnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_alternate();
        test_backpressure();
        test_reset_exec();
`ifdef CMP_ARB_STATS_EN
        test_stats();
`endif
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
